// File: rtl/axi_read_responder.sv
// axi_read_responder
//   AXI-style read slave serving single-outstanding bursts from an on-chip
//   synchronous-read backing store. Counterpart of the I$/D$ refill masters.
//
//   Ports
//     clk, rst_n                       clock, async active-low reset
//     ARADDR/ARLEN/ARID/ARVALID/ARREADY read address channel (ARLEN = beats)
//     RDATA/RID/RLAST/RVALID/RREADY     read data channel
//     init_we/init_addr/init_wdata      backdoor preload, honoured only when idle
//
//   Flow: IDLE accepts a request, WAIT burns LATENCY-1 further cycles, BURST
//   presents beats. RDATA is the RAM output register: it is loaded on entry
//   to BURST and on every non-final transfer, so the next word is already
//   prefetched when a beat completes and stays put while RREADY is low.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 26
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module axi_read_responder #(
  parameter int ADDR_WIDTH     = `ADDR_WIDTH,
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int MEM_WORDS_LOG2 = 12,
  parameter int LATENCY        = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic [7:0]                ARLEN,
  input  logic [3:0]                ARID,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [3:0]                RID,
  output logic                      RLAST,
  output logic                      RVALID,
  input  logic                      RREADY,
  input  logic                      init_we,
  input  logic [MEM_WORDS_LOG2-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0]     init_wdata
);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  localparam int              MEM_WORDS = 1 << MEM_WORDS_LOG2;
  localparam logic [3:0]      LAT_M1    = 4'(LATENCY - 1);
  localparam logic [MEM_WORDS_LOG2-1:0] IDX_ONE = MEM_WORDS_LOG2'(1);

  state_t                    state, state_nxt;
  logic [DATA_WIDTH-1:0]     mem [MEM_WORDS];
  logic [MEM_WORDS_LOG2-1:0] idx;
  logic [MEM_WORDS_LOG2-1:0] idx_inc;
  logic [3:0]                lat_cnt;
  logic [4:0]                beats_left;
  logic [4:0]                ar_beats;
  logic [3:0]                rid_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      ar_fire, r_fire, last_beat;

  // Byte-lane bits and address bits above the store are don't-care (aliasing).
  logic unused_addr;
  assign unused_addr = ^{ARADDR[ADDR_WIDTH-1:MEM_WORDS_LOG2+2], ARADDR[1:0]};

  // ARLEN is a plain beat count: 0 means one beat, anything above 16 clamps.
  assign ar_beats  = (ARLEN == 8'd0) ? 5'd1 :
                     (ARLEN > 8'd16) ? 5'd16 : ARLEN[4:0];
  assign last_beat = (beats_left == 5'd1);
  assign idx_inc   = idx + IDX_ONE;   // wraps modulo the store size
  assign ar_fire   = ARVALID & ARREADY;
  assign r_fire    = RVALID & RREADY;

  assign RDATA = rdata_q;
  assign RID   = rid_q;
  assign RLAST = (state == BURST) && last_beat;

  always_comb begin
    state_nxt = state;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    case (state)
      IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) state_nxt = WAIT;
      end
      WAIT: begin
        if (lat_cnt == 4'd0) state_nxt = BURST;
      end
      BURST: begin
        RVALID = 1'b1;
        if (RREADY && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      lat_cnt    <= '0;
      beats_left <= '0;
      rid_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (ar_fire) begin
          idx        <= ARADDR[MEM_WORDS_LOG2+1:2];
          lat_cnt    <= LAT_M1;
          beats_left <= ar_beats;
          rid_q      <= ARID;
        end
        WAIT: begin
          // Last WAIT cycle fetches the first beat so it appears with RVALID.
          if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
          else                 rdata_q <= mem[idx];
        end
        BURST: if (r_fire) begin
          beats_left <= beats_left - 5'd1;
          if (!last_beat) begin
            idx     <= idx_inc;
            rdata_q <= mem[idx_inc];
          end
        end
        default: ;
      endcase
    end
  end

  // Backing store is never reset; preload is locked out while a burst is live.
  always_ff @(posedge clk) begin
    if (init_we && (state == IDLE)) mem[init_addr] <= init_wdata;
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder (default parameters, LATENCY=4).
module tb_axi_read_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [25:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [3:0]  ARID;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [3:0]  RID;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        init_we;
  logic [11:0] init_addr;
  logic [31:0] init_wdata;

  axi_read_responder dut (
    .clk(clk), .rst_n(rst_n),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RID(RID), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          nb;
  int          first_lat;
  logic [31:0] rd [0:31];
  logic        rl [0:31];
  logic [31:0] ex [0:31];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    init_we = 1'b1; init_addr = a; init_wdata = d;
    tick();
    init_we = 1'b0;
  endtask

  // Issue one request and collect beats. stall: hold RREADY low 2 cycles on
  // beats 1 and 2. poke: fire init_we at poke_addr while the first beat shows.
  task automatic run_burst(input logic [25:0] addr, input logic [7:0] len, input logic [3:0] id,
                           input bit stall, input bit poke, input logic [11:0] poke_addr);
    int          waited;
    bit          have_hold, done;
    logic [31:0] hold_d;
    logic        hold_l;
    nb = 0; first_lat = -1; waited = 0; have_hold = 0; done = 0;
    hold_d = '0; hold_l = 1'b0;
    RREADY = 1'b1;
    ARADDR = addr; ARLEN = len; ARID = id; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    chk("arready_busy", ARREADY, 0);
    chk("rvalid_wait", RVALID, 0);
    for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
      tick();
      init_we = 1'b0;
      if (RVALID) begin
        if (first_lat < 0) begin
          first_lat = cyc;
          if (poke) begin
            init_we = 1'b1; init_addr = poke_addr; init_wdata = 32'hDEAD_BEEF;
          end
        end
        if (have_hold) begin
          chk("stall_rdata", RDATA, hold_d);
          chk("stall_rlast", RLAST, hold_l);
        end
        chk("rid", RID, id);
        if (stall && (nb == 1 || nb == 2) && waited < 2) begin
          RREADY = 1'b0; waited++;
          have_hold = 1; hold_d = RDATA; hold_l = RLAST;
        end else begin
          RREADY = 1'b1; waited = 0; have_hold = 0;
          if (nb < 32) begin rd[nb] = RDATA; rl[nb] = RLAST; end
          nb++;
          if (RLAST) done = 1;
        end
      end
    end
    if (!done) chk("burst_timeout", 0, 1);
    else begin
      tick();
      init_we = 1'b0;
      chk("arready_after", ARREADY, 1);
      chk("rvalid_after", RVALID, 0);
    end
    RREADY = 1'b1;
  endtask

  task automatic check_beats(input int n);
    chk("beat_count", nb, n);
    for (int i = 0; i < n && i < nb; i++) begin
      chk("rdata", rd[i], ex[i]);
      chk("rlast", {31'd0, rl[i]}, (i == n - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    bit rst_done;
    rst_n = 1'b0; ARADDR = '0; ARLEN = '0; ARID = '0; ARVALID = 1'b0;
    RREADY = 1'b1; init_we = 1'b0; init_addr = '0; init_wdata = '0;

    // Reset state
    #2;
    chk("rst0_arready", ARREADY, 1);
    chk("rst0_rvalid", RVALID, 0);
    chk("rst0_rlast", RLAST, 0);
    chk("rst0_rdata", RDATA, 0);
    chk("rst0_rid", RID, 0);
    #10 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++)  preload(12'h040 + 12'(i), 32'hA0A0_0000 + i);
    for (int i = 0; i < 16; i++) preload(12'h080 + 12'(i), 32'hB000_0000 + i);
    preload(12'hFFF, 32'hF0F0_F0F0);
    preload(12'h000, 32'h2222_2222);
    preload(12'h010, 32'h5A5A_5A5A);

    // Basic 4-beat burst, back-to-back
    run_burst(26'h100, 8'd4, 4'd3, 0, 0, 12'h0);
    chk("latency", first_lat, 4);
    for (int i = 0; i < 4; i++) ex[i] = 32'hA0A0_0000 + i;
    check_beats(4);

    // Same burst with stalls on beats 1 and 2
    run_burst(26'h100, 8'd4, 4'd7, 1, 0, 12'h0);
    chk("latency_stall", first_lat, 4);
    check_beats(4);

    // Wrap at the top of the store
    run_burst(26'h3FFC, 8'd2, 4'd1, 0, 0, 12'h0);
    ex[0] = 32'hF0F0_F0F0; ex[1] = 32'h2222_2222;
    check_beats(2);

    // Upper address bits alias onto the store
    run_burst(26'h100 | 26'h100000, 8'd1, 4'd4, 0, 0, 12'h0);
    ex[0] = 32'hA0A0_0000;
    check_beats(1);

    // ARLEN=0 -> one beat
    run_burst(26'h040, 8'd0, 4'd6, 0, 0, 12'h0);
    ex[0] = 32'h5A5A_5A5A;
    check_beats(1);

    // ARLEN=20 -> clamped to 16
    run_burst(26'h200, 8'd20, 4'd15, 0, 0, 12'h0);
    for (int i = 0; i < 16; i++) ex[i] = 32'hB000_0000 + i;
    check_beats(16);

    // Preload during BURST is ignored; re-read confirms memory unchanged
    run_burst(26'h100, 8'd4, 4'd2, 0, 1, 12'h041);
    for (int i = 0; i < 4; i++) ex[i] = 32'hA0A0_0000 + i;
    check_beats(4);
    run_burst(26'h100, 8'd4, 4'd2, 0, 0, 12'h0);
    check_beats(4);

    // Async reset mid-burst (beat 2 of 8)
    ARADDR = 26'h200; ARLEN = 8'd8; ARID = 4'd9; ARVALID = 1'b1; RREADY = 1'b1;
    tick();
    ARVALID = 1'b0;
    nb = 0; rst_done = 0;
    for (int cyc = 0; cyc < 20 && !rst_done; cyc++) begin
      tick();
      if (RVALID) begin
        if (nb == 2) begin
          chk("pre_rst_rdata", RDATA, 32'hB000_0002);
          #2 rst_n = 1'b0;
          #1;
          chk("arst_rvalid", RVALID, 0);
          chk("arst_arready", ARREADY, 1);
          chk("arst_rlast", RLAST, 0);
          chk("arst_rdata", RDATA, 0);
          chk("arst_rid", RID, 0);
          rst_done = 1;
        end
        nb++;
      end
    end
    if (!rst_done) chk("rst_timeout", 0, 1);
    tick();
    chk("rst_hold_rvalid", RVALID, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_rvalid", RVALID, 0);
    chk("post_rst_arready", ARREADY, 1);
    run_burst(26'h100, 8'd4, 4'd3, 0, 0, 12'h0);
    chk("latency_post_rst", first_lat, 4);
    check_beats(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_responder.md
AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH (26): byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (32): word width.
REQ-003 SHALL have parameter MEM_WORDS_LOG2, default 12: backing store holds 2^MEM_WORDS_LOG2 words.
REQ-004 SHALL have parameter LATENCY, default 4, legal 1..15: cycles from AR handshake to first RVALID.
REQ-005 SHALL have these ports, one clock domain; reset is asynchronous and active-low:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ARADDR  in  ADDR_WIDTH  burst start byte address; bits [1:0] ignored
- ARLEN  in  8  burst beat count
- ARID  in  4  transaction ID
- ARVALID  in  1  read request valid
- ARREADY  out  1  responder accepts request
- RDATA  out  DATA_WIDTH  read beat data
- RID  out  4  echo of accepted ARID
- RLAST  out  1  final beat of burst
- RVALID  out  1  beat valid
- RREADY  in  1  master accepts beat
- init_we  in  1  backdoor preload write enable
- init_addr  in  MEM_WORDS_LOG2  preload word index
- init_wdata  in  DATA_WIDTH  preload data
REQ-006 SHALL be the slave side of the axi_read_address / axi_read_data pair, i.e. the counterpart of the instruction- and data-cache refill masters.

Function
REQ-007 SHALL implement states IDLE, WAIT, BURST; exactly one burst outstanding.
REQ-008 IDLE: ARREADY=1, RVALID=0; on ARVALID&ARREADY at an edge, latch word index = ARADDR[MEM_WORDS_LOG2+1:2], beat count, ARID; go to WAIT.
REQ-009 Beat count SHALL be ARLEN as a count of words (not AXI len-1); ARLEN=0 treated as 1; ARLEN>16 clamped to 16.
REQ-010 ARREADY SHALL be 0 in WAIT and BURST.
REQ-011 WAIT: counter loaded with LATENCY-1 at accept, decremented each cycle; at 0 enter BURST; first RVALID SHALL be high exactly LATENCY cycles after the accepting edge.
REQ-012 BURST: RVALID=1 with RDATA=mem[index], RID=latched ARID; beat transfers on RVALID&RREADY at an edge.
REQ-013 With RREADY held 1, beats SHALL issue back-to-back, one per cycle, no bubbles.
REQ-014 With RREADY=0, RDATA, RID, RLAST, RVALID SHALL hold stable until the transfer.
REQ-015 Word index SHALL increment by 1 per transferred beat, wrapping modulo 2^MEM_WORDS_LOG2; address bits above the store are ignored (aliasing).
REQ-016 RLAST SHALL be 1 only while the final beat is presented.
REQ-017 On final-beat transfer SHALL return to IDLE; ARREADY=1 the following cycle; RVALID=0 that cycle.
REQ-018 Backing store SHALL be synchronous-read RAM; the implementation prefetches so REQ-013/REQ-014 hold.
REQ-019 init_we SHALL write init_wdata to mem[init_addr] at the edge only in IDLE; ignored in WAIT/BURST.
REQ-020 ARVALID during WAIT/BURST SHALL be left pending (not accepted) until IDLE; the master holds it.

Reset
REQ-021 rst_n=0 SHALL immediately (asynchronously) force state IDLE, ARREADY=1, RVALID=0, RLAST=0, RDATA=0, RID=0, counters 0.
REQ-022 Reset mid-burst SHALL abort the burst with no further beats; memory contents are not cleared by reset.

Verification
REQ-023 Preload mem[0x40..0x43]=A0..A3; AR ARADDR=0x100, ARLEN=4, ARID=3, RREADY=1 -> RVALID first high 4 cycles after accept; RDATA A0,A1,A2,A3 on consecutive cycles, RID=3, RLAST only on A3; ARREADY=1 next cycle.
REQ-024 Same burst, RREADY low on cycles of beats 1 and 2 for 2 cycles each -> RDATA/RLAST stable while stalled; order A0..A3 unchanged; no lost or duplicated beat.
REQ-025 ARADDR=(4095*4), ARLEN=2, mem[4095]=F, mem[0]=Z -> beats F then Z.
REQ-026 ARLEN=0 -> one beat with RLAST=1; ARLEN=20 -> exactly 16 beats.
REQ-027 rst_n low on beat 2 of an 8-beat burst -> RVALID=0 and ARREADY=1 without waiting for a clock edge; new request after release served correctly from unchanged memory.
REQ-028 init_we during BURST to the next-beat address -> memory unchanged; returned beat equals the pre-burst value.
